// File: rtl/mem_access_sequencer.sv
// Data-memory access sequencer for the MEM stage: checks legality/alignment, places store lanes,
// handshakes with data memory and extends load results. Optional ACCESS timeout under MEM_TIMEOUT_EN.
module mem_access_sequencer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic        mem_read_control,
   input  logic        mem_write_control,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] load_data,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE,
      S_ERR
   } state_e;

   state_e      state_q;
   logic        dmem_req_q;
   logic        dmem_we_q;
   logic [31:0] dmem_addr_q;
   logic [31:0] dmem_wdata_q;
   logic [3:0]  dmem_be_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] load_data_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic        rd;
   logic        wr;
   logic        req_ok;
   logic        req_bad;

   function automatic logic is_legal(input logic r, input logic w, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (r) begin
         ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end else if (w) begin
         ok = f3 inside {3'b000, 3'b001, 3'b010};
      end
      return ok;
   endfunction

   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      case (f3[1:0])
         2'b01:   ok = ~off[0];
         2'b10:   ok = (off == 2'b00);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] q;
      case (f3[1:0])
         2'b00:   q = {4{d[7:0]}};
         2'b01:   q = {2{d[15:0]}};
         default: q = d;
      endcase
      return q;
   endfunction

   // Shift the addressed lane down to bit 0, then sign- or zero-extend by access size.
   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] q;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  q = {{24{sh[7]}}, sh[7:0]};
         3'b001:  q = {{16{sh[15]}}, sh[15:0]};
         3'b100:  q = {24'h000000, sh[7:0]};
         3'b101:  q = {16'h0000, sh[15:0]};
         default: q = rdata;
      endcase
      return q;
   endfunction

   assign rd      = mem_read_control;
   assign wr      = mem_write_control;
   assign req_ok  = valid_in & (rd ^ wr) & is_legal(rd, wr, funct3) & is_aligned(funct3, addr[1:0]);
   assign req_bad = valid_in & (rd | wr) & ~req_ok;

   assign stall      = ((state_q == S_IDLE) & req_ok) | (state_q == S_ACCESS);
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign dmem_be    = dmem_be_q;
   assign done       = done_q;
   assign err        = err_q;
   assign load_data  = load_data_q;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             expire;

   assign expire = (cnt_q == CNT_LAST);
   assign cnt_d  = cnt_q + 1'b1;
`else
   // Without the timeout feature the depth parameter has no consumer.
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= 32'h0;
         dmem_wdata_q <= 32'h0;
         dmem_be_q    <= 4'h0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         load_data_q  <= 32'h0;
         f3_q         <= 3'b000;
         off_q        <= 2'b00;
`ifdef MEM_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_ok) begin
                  state_q      <= S_ACCESS;
                  dmem_req_q   <= 1'b1;
                  dmem_we_q    <= wr;
                  dmem_addr_q  <= {addr[31:2], 2'b00};
                  dmem_be_q    <= lane_be(funct3, addr[1:0]);
                  dmem_wdata_q <= wr ? lane_wdata(funct3, wdata) : 32'h0;
                  f3_q         <= funct3;
                  off_q        <= addr[1:0];
`ifdef MEM_TIMEOUT_EN
                  cnt_q        <= '0;
`endif
               end else if (req_bad) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end
            end
            S_ACCESS: begin
               // An ack in the expiry cycle still completes the access.
               if (dmem_ack) begin
                  state_q    <= S_DONE;
                  dmem_req_q <= 1'b0;
                  done_q     <= 1'b1;
                  if (!dmem_we_q) begin
                     load_data_q <= extend_load(f3_q, off_q, dmem_rdata);
                  end
`ifdef MEM_TIMEOUT_EN
               end else if (expire) begin
                  state_q    <= S_ERR;
                  dmem_req_q <= 1'b0;
                  err_q      <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
`endif
               end
            end
            S_DONE:  state_q <= S_IDLE;
            S_ERR:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: loads, stores, faults, reset abort and (with MEM_TIMEOUT_EN) timeout.
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic        mem_read_control;
   logic        mem_write_control;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall;
   logic        done;
   logic [31:0] load_data;
   logic        err;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mem_access_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .valid_in          (valid_in),
      .mem_read_control  (mem_read_control),
      .mem_write_control (mem_write_control),
      .funct3            (funct3),
      .addr              (addr),
      .wdata             (wdata),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_be           (dmem_be),
      .dmem_ack          (dmem_ack),
      .dmem_rdata        (dmem_rdata),
      .stall             (stall),
      .done              (done),
      .load_data         (load_data),
      .err               (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      valid_in          = 1'b1;
      mem_read_control  = r;
      mem_write_control = w;
      funct3            = f3;
      addr              = a;
      wdata             = d;
   endtask

   task automatic clear_in();
      valid_in          = 1'b0;
      mem_read_control  = 1'b0;
      mem_write_control = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
      issue(1'b1, 1'b0, f3, a, 32'h0);
      tick();
      chk32({tag, "_be"}, {28'h0, dmem_be}, {28'h0, exp_be});
      chk32({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
      clear_in();
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      tick();
      chk1({tag, "_done"}, done, 1'b1);
      chk32({tag, "_data"}, load_data, exp_data);
      dmem_ack = 1'b0;
      tick();
   endtask

   task automatic do_err(input string tag, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a);
      issue(r, w, f3, a, 32'h0);
      #1;
      chk1({tag, "_stall"}, stall, 1'b0);
      tick();
      chk1({tag, "_err"}, err, 1'b1);
      chk1({tag, "_req"}, dmem_req, 1'b0);
      clear_in();
      tick();
      chk1({tag, "_err_clr"}, err, 1'b0);
      chk1({tag, "_req_off"}, dmem_req, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      funct3     = 3'b000;
      addr       = 32'h0;
      wdata      = 32'h0;
      clear_in();
      tick();
      tick();
      chk1("rst_req", dmem_req, 1'b0);
      chk1("rst_we", dmem_we, 1'b0);
      chk32("rst_addr", dmem_addr, 32'h0);
      chk32("rst_wdata", dmem_wdata, 32'h0);
      chk32("rst_be", {28'h0, dmem_be}, 32'h0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk32("rst_ldata", load_data, 32'h0);
      chk1("rst_stall", stall, 1'b0);
      #2 rst_n = 1'b1;
      tick();

      // LW at minimum latency, with a competing request held through DONE
      issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
      #1;
      chk1("lw_stall_c0", stall, 1'b1);
      chk1("lw_req_c0", dmem_req, 1'b0);
      tick();
      chk1("lw_req_c1", dmem_req, 1'b1);
      chk1("lw_we_c1", dmem_we, 1'b0);
      chk32("lw_be_c1", {28'h0, dmem_be}, 32'hF);
      chk32("lw_addr_c1", dmem_addr, 32'h0000_0100);
      chk1("lw_stall_c1", stall, 1'b1);
      clear_in();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      tick();
      chk1("lw_done_c2", done, 1'b1);
      chk1("lw_req_c2", dmem_req, 1'b0);
      chk1("lw_stall_c2", stall, 1'b0);
      chk32("lw_data_c2", load_data, 32'hDEAD_BEEF);
      dmem_ack = 1'b0;
      issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
      #1;
      chk1("done_stall", stall, 1'b0);
      tick();
      chk1("done_no_accept", dmem_req, 1'b0);
      chk1("done_pulse_end", done, 1'b0);
      clear_in();
      tick();

      do_load("lb",  3'b000, 32'h0000_0103, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
      do_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
      do_load("lhu", 3'b101, 32'h0000_0102, 32'h80FF_0000, 4'b1100, 32'h0000_80FF);
      do_load("lh",  3'b001, 32'h0000_0102, 32'h80FF_0000, 4'b1100, 32'hFFFF_80FF);

      // Ack while idle must be ignored
      dmem_ack = 1'b1;
      tick();
      chk1("idle_ack_done", done, 1'b0);
      dmem_ack = 1'b0;

      // SH with one wait cycle before ack
      issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
      tick();
      chk1("sh_req", dmem_req, 1'b1);
      chk1("sh_we", dmem_we, 1'b1);
      chk32("sh_addr", dmem_addr, 32'h0000_0200);
      chk32("sh_be", {28'h0, dmem_be}, 32'hC);
      chk32("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
      clear_in();
      wdata = 32'h0;
      tick();
      chk1("sh_req_hold", dmem_req, 1'b1);
      chk32("sh_wdata_hold", dmem_wdata, 32'hABCD_ABCD);
      chk32("sh_addr_hold", dmem_addr, 32'h0000_0200);
      dmem_ack = 1'b1;
      tick();
      chk1("sh_done", done, 1'b1);
      chk32("sh_ldata_kept", load_data, 32'hFFFF_80FF);
      dmem_ack = 1'b0;
      tick();

      issue(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00EF);
      tick();
      chk32("sb_be", {28'h0, dmem_be}, 32'h2);
      chk32("sb_wdata", dmem_wdata, 32'hEFEF_EFEF);
      chk32("sb_addr", dmem_addr, 32'h0000_0200);
      clear_in();
      dmem_ack = 1'b1;
      tick();
      chk1("sb_done", done, 1'b1);
      dmem_ack = 1'b0;
      tick();

      do_err("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_0101);
      do_err("rd_wr",   1'b1, 1'b1, 3'b010, 32'h0000_0100);
      do_err("st_ill",  1'b0, 1'b1, 3'b100, 32'h0000_0100);
      do_err("lh_mis",  1'b1, 1'b0, 3'b001, 32'h0000_0101);

      // valid without read/write: no action
      issue(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
      #1;
      chk1("nop_stall", stall, 1'b0);
      tick();
      chk1("nop_req", dmem_req, 1'b0);
      chk1("nop_err", err, 1'b0);
      clear_in();

`ifdef MEM_TIMEOUT_EN
      issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
      tick();
      clear_in();
      chk1("to_req_1", dmem_req, 1'b1);
      tick();
      tick();
      tick();
      chk1("to_req_4", dmem_req, 1'b1);
      tick();
      chk1("to_err", err, 1'b1);
      chk1("to_req_drop", dmem_req, 1'b0);
      tick();
      chk1("to_err_clr", err, 1'b0);
      issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
      tick();
      clear_in();
      tick();
      tick();
      tick();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFE_F00D;
      tick();
      chk1("to_ack_done", done, 1'b1);
      chk1("to_ack_noerr", err, 1'b0);
      chk32("to_ack_data", load_data, 32'hCAFE_F00D);
      dmem_ack = 1'b0;
      tick();
`else
      issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
      tick();
      clear_in();
      repeat (6) tick();
      chk1("wait_req", dmem_req, 1'b1);
      chk1("wait_noerr", err, 1'b0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1234_5678;
      tick();
      chk1("wait_done", done, 1'b1);
      chk32("wait_data", load_data, 32'h1234_5678);
      dmem_ack = 1'b0;
      tick();
`endif

      // Asynchronous reset in the middle of an access
      issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
      tick();
      chk1("ra_req", dmem_req, 1'b1);
      clear_in();
      #2 rst_n = 1'b0;
      #1;
      chk1("ra_req_drop", dmem_req, 1'b0);
      chk32("ra_ldata", load_data, 32'h0);
      chk1("ra_stall", stall, 1'b0);
      dmem_ack = 1'b1;
      tick();
      #2 rst_n = 1'b1;
      tick();
      chk1("ra_no_done", done, 1'b0);
      chk1("ra_no_err", err, 1'b0);
      tick();
      chk1("ra_no_done2", done, 1'b0);
      chk1("ra_req_idle", dmem_req, 1'b0);
      dmem_ack = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum cycles spent in ACCESS awaiting dmem_ack.
REQ-002 Ports:
  - clk  in  1  sole clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
REQ-003 Port: valid_in  in  1  instruction present in MEM stage.
REQ-004 Ports:
  - mem_read_control  in  1  load, from decode control.
  - mem_write_control  in  1  store, from decode control.
REQ-005 Port: funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 Ports:
  - addr  in  32  ALU-computed effective address.
  - wdata  in  32  rs2 store data.
REQ-007 Ports:
  - dmem_req  out  1  memory request.
  - dmem_we  out  1  write enable.
  - dmem_addr  out  32  word-aligned address.
  - dmem_wdata  out  32  lane-placed data.
  - dmem_be  out  4  byte enables.
REQ-008 Ports:
  - dmem_ack  in  1  memory completion.
  - dmem_rdata  in  32  read word, valid with ack.
REQ-009 Ports:
  - stall  out  1  freeze upstream pipeline (combinational).
  - done  out  1  access complete pulse.
  - load_data  out  32  extended load result.
  - err  out  1  fault pulse.

Function
REQ-010 FSM states: IDLE, ACCESS, DONE, ERR; encoding is free.
REQ-011 IDLE with valid_in & (read XOR write) & legal & aligned: next state ACCESS; registered dmem_req=1, dmem_we=write, dmem_addr={addr[31:2],2'b00}, dmem_be/dmem_wdata loaded.
REQ-012 Legal funct3: load {000,001,010,100,101}; store {000,001,010}. Aligned: halfword addr[0]=0, word addr[1:0]=0.
REQ-013 IDLE with valid_in & (read&write, illegal funct3, or misaligned): next state ERR; no dmem_req is ever issued.
REQ-014 Store lanes: SB be=0001<<addr[1:0], data byte replicated x4; SH be=0011<<addr[1:0], halfword replicated x2; SW be=1111.
REQ-015 Load: be per REQ-014; on ack, select lane by addr[1:0], sign-extend (B/H) or zero-extend (BU/HU), register into load_data.
REQ-016 ACCESS: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be held stable until dmem_ack sampled high; then dmem_req=0, next state DONE.
REQ-017 DONE: done=1 for exactly one cycle, stall=0, load_data stable (unchanged for stores); next state IDLE unconditionally; no new request accepted in DONE.
REQ-018 ERR: err=1 for exactly one cycle, stall=0, dmem_req=0; next state IDLE.
REQ-019 stall = (IDLE & valid_in & (read|write) & legal & aligned & !(read&write)) | ACCESS.
REQ-020 Minimum latency: request seen cycle 0, dmem_req cycle 1, ack cycle 1 gives done cycle 2.
REQ-021 dmem_ack outside ACCESS is ignored.
REQ-022 valid_in without read/write in IDLE: no action, stall=0.

Reset
REQ-023 rst_n low: immediately state IDLE and outputs dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, done, err, load_data = 0; timeout counter = 0.
REQ-024 Reset during ACCESS drops dmem_req asynchronously; the access is abandoned without done or err.

Configuration
REQ-025 With MEM_TIMEOUT_EN defined: counter clears on ACCESS entry and increments each ACCESS cycle without ack; reaching TIMEOUT_CYCLES drops dmem_req and transitions to ERR. Ack in the same cycle as expiry wins (goes to DONE).
REQ-026 Without MEM_TIMEOUT_EN: no counter is present; ACCESS waits indefinitely for dmem_ack.

Verification
REQ-027 LW addr=0x100, ack on first ACCESS cycle, rdata=0xDEADBEEF -> dmem_req cycle 1, be=1111, done cycle 2, load_data=0xDEADBEEF, stall high cycles 0-1.
REQ-028 LB addr=0x103, rdata=0x80FF0000 -> load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-029 SH addr=0x202, wdata=0x1234ABCD -> dmem_addr=0x200, be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-030 LW addr=0x101 -> err pulse, dmem_req never high, stall low; read&write both high -> same.
REQ-031 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 ACCESS cycles, err pulse; ack on 4th cycle -> done instead.
REQ-032 rst_n low mid-ACCESS -> dmem_req=0 same cycle, state IDLE, no done/err after release.
